// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
// Shares the register file's single write port between two writeback
// requesters and tracks long-latency destinations in a 32-entry scoreboard.
//   port 0 (wb0_*) : single-cycle EX results
//   port 1 (wb1_*) : long-latency load / mul-div results
// Ports:
//   clk, rst (asynchronous, active low)
//   wb0_valid_i/addr_i/data_i -> wb0_ready_o   EX writeback handshake
//   wb1_valid_i/addr_i/data_i -> wb1_ready_o   long-latency writeback handshake
//   reg_waddr_o/wdata_o/wen_o                  registered register file write port
//   sb_set_i/sb_set_addr_i                     marks a destination busy on issue
//   rs1/rs2/rd_addr_i -> stall_o               RAW/WAW hazard query
//   busy_o                                     scoreboard state
// Optional build macro REGS_WB_ARB_PERF_EN adds conflict_cnt_o and stall_cnt_o,
// saturating 32-bit counters of dual-request cycles and stall cycles.
module regs_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb0_valid_i,
  input  logic [AW-1:0] wb0_addr_i,
  input  logic [DW-1:0] wb0_data_i,
  output logic          wb0_ready_o,
  input  logic          wb1_valid_i,
  input  logic [AW-1:0] wb1_addr_i,
  input  logic [DW-1:0] wb1_data_i,
  output logic          wb1_ready_o,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic          reg_wen_o,
  input  logic          sb_set_i,
  input  logic [AW-1:0] sb_set_addr_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          stall_o,
  output logic [31:0]   busy_o
`ifdef REGS_WB_ARB_PERF_EN
  ,
  output logic [31:0]   conflict_cnt_o,
  output logic [31:0]   stall_cnt_o
`endif
);

  // last_grant_q holds the index of the port that most recently transferred.
  logic          last_grant_q, last_grant_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [31:0]   busy_q, busy_d;
  logic          xfer0_s, xfer1_s;
  logic          stall_s;

  // Round-robin grant: a lone requester always wins; on a conflict the port
  // that did not win last time is granted.
  always_comb begin
    wb0_ready_o = wb0_valid_i & (~wb1_valid_i | last_grant_q);
    wb1_ready_o = wb1_valid_i & (~wb0_valid_i | ~last_grant_q);
    xfer0_s     = wb0_valid_i & wb0_ready_o;
    xfer1_s     = wb1_valid_i & wb1_ready_o;
  end

  // Hazard check against the registered scoreboard; x0 never matches.
  always_comb begin
    stall_s = ((rs1_addr_i != {AW{1'b0}}) & busy_q[rs1_addr_i]) |
              ((rs2_addr_i != {AW{1'b0}}) & busy_q[rs2_addr_i]) |
              ((rd_addr_i  != {AW{1'b0}}) & busy_q[rd_addr_i]);
  end

  // Next-state for grant pointer, write port register and scoreboard.
  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    if (xfer1_s) begin
      last_grant_d = 1'b1;
      wen_d        = (wb1_addr_i != {AW{1'b0}});
      waddr_d      = wb1_addr_i;
      wdata_d      = wb1_data_i;
      if (wb1_addr_i != {AW{1'b0}}) begin
        busy_d[wb1_addr_i] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
    end else if (xfer0_s) begin
      last_grant_d = 1'b0;
      wen_d        = (wb0_addr_i != {AW{1'b0}});
      waddr_d      = wb0_addr_i;
      wdata_d      = wb0_data_i;
    end else begin
      last_grant_d = last_grant_q;
    end
    // Applied after the clear so a same-cycle issue to the same register wins.
    if (sb_set_i && (sb_set_addr_i != {AW{1'b0}})) begin
      busy_d[sb_set_addr_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers; reset drops any pending write and empties the scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      wen_q        <= 1'b0;
      waddr_q      <= {AW{1'b0}};
      wdata_q      <= {DW{1'b0}};
      busy_q       <= 32'h0000_0000;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_wen_o   = wen_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign stall_o     = stall_s;

`ifdef REGS_WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating performance counters.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (wb0_valid_i && wb1_valid_i && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_q <= 32'h0000_0000;
      stall_cnt_q    <= 32'h0000_0000;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters:
  - port 0: the single-cycle EX result;
  - port 1: long-latency load / mul-div results.
- Also keeps a 32-entry scoreboard of destinations with a long-latency write still outstanding, and raises a stall to issue on RAW or WAW hazards against them.
- Sits between EX/LSU and the register file write port (waddr/wdata/wen).

Parameters:
- AW, 5, register address width (32 architectural registers).
- DW, 32, data width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active low
- wb0_valid_i  input  1  EX writeback request
- wb0_addr_i  input  AW  EX destination register
- wb0_data_i  input  DW  EX result
- wb0_ready_o  output  1  EX request accepted this cycle
- wb1_valid_i  input  1  long-latency writeback request
- wb1_addr_i  input  AW  long-latency destination register
- wb1_data_i  input  DW  long-latency result
- wb1_ready_o  output  1  long-latency request accepted this cycle
- reg_waddr_o  output  AW  register file write address
- reg_wdata_o  output  DW  register file write data
- reg_wen_o  output  1  register file write enable
- sb_set_i  input  1  issue of a long-latency op; marks sb_set_addr_i busy
- sb_set_addr_i  input  AW  destination of the issued op
- rs1_addr_i  input  AW  hazard query, source 1 of the instruction in issue
- rs2_addr_i  input  AW  hazard query, source 2
- rd_addr_i  input  AW  hazard query, destination
- stall_o  output  1  hazard present; issue must hold
- busy_o  output  32  scoreboard state, bit n = register n pending

Behaviour:
- Reset (rst low, asynchronous):
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0;
  - busy=0;
  - last_grant=1, so port 0 wins the first conflict.
- Handshake:
  - A transfer occurs on a port when valid and ready are both high in the same cycle.
  - ready is combinational from the valid inputs and last_grant.
  - A requester must hold valid, addr and data stable until it is accepted.
- Arbitration:
  - Only one valid: that port gets ready=1.
  - Both valid: round-robin; the port not in last_grant wins and the loser sees ready=0.
  - last_grant updates only on a transfer.
  - Neither valid: both ready=0 and last_grant holds.
- Write port:
  - Registered, one cycle of latency.
  - Transfer in cycle N drives reg_wen_o/reg_waddr_o/reg_wdata_o in cycle N+1.
  - reg_wen_o=0 in any cycle following no transfer.
- x0 handling:
  - A transfer to address 0 is accepted (ready=1), but reg_wen_o stays 0.
  - x0 never sets, clears or matches in the scoreboard.
- Scoreboard:
  - Set: on the edge, sb_set_i with a nonzero address sets busy[sb_set_addr_i].
  - Clear: on the edge, a port-1 transfer clears busy[wb1_addr_i].
  - Set and clear of the same address in the same cycle: set wins, because a new op was issued.
  - Port-0 transfers never touch the scoreboard.
- Stall:
  - stall_o = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (rd!=0 & busy[rd]).
  - stall_o is combinational from the registered busy.
  - A clear on edge N drops stall in cycle N+1, the same cycle the write appears on the register file port.
  - The register file's write forwarding makes the data visible in that cycle.
- Setting an address that is already busy is illegal: issue is stalled by the rd term.
  - Under that illegal set, busy stays 1 and there is no other effect.
- Reset asserted mid-operation: any pending registered write is dropped, and busy clears immediately.

Optional Feature:
- Macro: REGS_WB_ARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt_o [31:0]: it increments each cycle both valids are high.
  - Adds output stall_cnt_o [31:0]: it increments each cycle stall_o is high.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Only wb0 valid (addr 5, data 0x1234) -> wb0_ready_o=1 same cycle; next cycle reg_wen_o=1, waddr=5, wdata=0x1234.
- Both valid from reset for 4 cycles (wb0 addr 3, wb1 addr 4) -> grants 0,1,0,1; reg_waddr_o sequence 3,4,3,4 one cycle late.
- sb_set_i addr 7, then rs1_addr_i=7 -> stall_o=1 and busy_o=0x80; wb1 transfer to 7 -> stall_o=0 next cycle, with reg_wen_o=1 for 7 in that cycle.
- Same cycle sb_set addr 9 and wb1 transfer addr 9 -> busy_o[9]=1 afterwards; write to 9 still issued.
- wb0 to addr 0 and sb_set addr 0 -> ready=1, reg_wen_o stays 0, busy_o stays 0, stall_o=0 for rs1=0.
- busy=0x80 and a pending write, then rst low mid-cycle -> outputs 0 and busy_o=0 immediately, without a clock edge.
